mux_int_chk: RTL and testbench

Self-checking response monitor for the two-select integer mux. It sits at the mux output, opposite the stimulus generator that drives `in_sel1`, `in_sel2`, `in_data1` and `in_data2`. Each cycle it computes the expected mux output from the same inputs, delays it by the DUT latency, and compares it against `mux_out`. It reports compare and error counts, captures the first mismatch, and gives a pass/fail verdict when the run finishes.

---
 rtl/mux_int_chk.sv | 124 ++++++++++++
 tb/tb_mux_int_chk.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_int_chk.sv
// mux_int_chk: response monitor for the two-select integer mux; predicts, delays and compares
// the mux output, counting compares/mismatches and latching the first mismatch.
module mux_int_chk #(
  parameter int W           = 16,
  parameter int LAT         = 1,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         finish,
  input  logic         in_sel1,
  input  logic         in_sel2,
  input  logic [W-1:0] in_data1,
  input  logic [W-1:0] in_data2,
  input  logic [W-1:0] mux_out,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         err_pulse,
  output logic [15:0]  cmp_cnt,
  output logic [15:0]  err_cnt,
  output logic [W-1:0] first_exp,
  output logic [W-1:0] first_act,
  output logic [15:0]  first_idx
);
  typedef enum logic [2:0] {IDLE, ARM, CHECK, HOLD, DONE} state_t;
  // ARM spans LAT-1 cycles so the first compare lands exactly LAT edges after start
  localparam logic [2:0] ARM_N = 3'(LAT > 1 ? LAT - 2 : 0);
  state_t       state_q, state_d;
  logic [2:0]   arm_q, arm_d;
  logic [15:0]  cmp_q, cmp_d, err_q, err_d, idx_q, idx_d;
  logic [W-1:0] fexp_q, fexp_d, fact_q, fact_d;
  logic [W-1:0] exp_d, exp_dl;
  logic         busy_q, done_q, pass_q, pulse_q;
  logic         go, miss;
  assign exp_d = in_sel1 ? in_data1 : in_sel2 ? in_data2 : '0;
  generate
    if (LAT == 0) begin : g_nodl
      assign exp_dl = exp_d;
    end else begin : g_dl
      logic [W-1:0] dl_q [LAT];
      always_ff @(posedge clk) begin
        if (reset) begin
          dl_q <= '{default: '0};
        end else begin
          dl_q[0] <= exp_d;
          for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign exp_dl = dl_q[LAT-1];
    end
  endgenerate
  always_comb begin
    go      = start && (state_q == IDLE || state_q == DONE);
    miss    = state_q == CHECK && mux_out != exp_dl;
    state_d = state_q;
    arm_d   = arm_q;
    cmp_d   = cmp_q;
    err_d   = err_q;
    idx_d   = idx_q;
    fexp_d  = fexp_q;
    fact_d  = fact_q;
    if (go) begin
      state_d = LAT > 1 ? ARM : CHECK;
      arm_d   = ARM_N;
      cmp_d   = '0;
      err_d   = '0;
      idx_d   = '0;
      fexp_d  = '0;
      fact_d  = '0;
    end else if (state_q == ARM) begin
      state_d = arm_q == '0 ? CHECK : ARM;
      arm_d   = arm_q - 3'd1;
    end else if (state_q == CHECK) begin
      state_d = finish ? DONE : (STOP_ON_ERR && miss) ? HOLD : CHECK;
      cmp_d   = cmp_q + 16'(cmp_q != '1);
      err_d   = err_q + 16'(miss && err_q != '1);
      if (miss && err_q == '0) begin
        idx_d  = cmp_q;
        fexp_d = exp_dl;
        fact_d = mux_out;
      end
    end else if (state_q == HOLD && finish) begin
      state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      arm_q   <= '0;
      cmp_q   <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      fexp_q  <= '0;
      fact_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cmp_q   <= cmp_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      fexp_q  <= fexp_d;
      fact_q  <= fact_d;
      busy_q  <= state_d == ARM || state_d == CHECK || state_d == HOLD;
      done_q  <= state_d == DONE;
      pass_q  <= state_d == DONE && err_d == '0 && cmp_d != '0;
      pulse_q <= miss;
    end
  end
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_pulse = pulse_q;
  assign cmp_cnt   = cmp_q;
  assign err_cnt   = err_q;
  assign first_exp = fexp_q;
  assign first_act = fact_q;
  assign first_idx = idx_q;
endmodule

// File: tb/tb_mux_int_chk.sv
// tb_mux_int_chk: four checker instances (LAT 1/0/7, and LAT 1 with stop-on-error) watched by a
// scoreboard fed from a run-level reference model.
module tb_mux_int_chk;
  typedef struct packed {
    logic [15:0] cmp;
    logic [15:0] err;
    logic [15:0] fe;
    logic [15:0] fa;
    logic [15:0] fi;
    logic        pass;
  } rec_t;
  logic        clk = 1'b0;
  logic        reset, start, finish, in_sel1, in_sel2;
  logic [15:0] in_data1, in_data2;
  logic [15:0] mux_out [4];
  logic        busy [4], done [4], pass [4], err_pulse [4], done_p [4];
  logic [15:0] cmp_cnt [4], err_cnt [4], first_exp [4], first_act [4], first_idx [4];
  logic [15:0] ref_e [0:8191];
  logic [15:0] act [4][0:8191];
  rec_t        rq [4][$];
  logic [15:0] pq [4][$];
  rec_t        mr;
  int          e = 0, checks = 0, failures = 0;
  always #5 clk = ~clk;
  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      mux_int_chk #(.W(16), .LAT(g == 1 ? 0 : g == 2 ? 7 : 1), .STOP_ON_ERR(1'(g == 3))) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_sel1(in_sel1), .in_sel2(in_sel2), .in_data1(in_data1), .in_data2(in_data2),
        .mux_out(mux_out[g]), .busy(busy[g]), .done(done[g]), .pass(pass[g]),
        .err_pulse(err_pulse[g]), .cmp_cnt(cmp_cnt[g]), .err_cnt(err_cnt[g]),
        .first_exp(first_exp[g]), .first_act(first_act[g]), .first_idx(first_idx[g]));
    end
  endgenerate
  function automatic int lat_of(input int d);
    return d == 1 ? 0 : d == 2 ? 7 : 1;
  endfunction
  function automatic logic [15:0] mux_ref(input logic s1, s2, input logic [15:0] d1, d2);
    return s1 ? d1 : s2 ? d2 : 16'd0;
  endfunction
  // Result of a run started at edge s and evaluated through edge f: compares begin at edge
  // s+max(LAT,1) and pair mux_out at edge t with the mux function of the inputs at edge t-LAT.
  function automatic rec_t model(input int d, input int s, input int f);
    rec_t r = '0;
    int   l = lat_of(d);
    for (int t = s + (l > 0 ? l : 1); t <= f; t++) begin
      if (act[d][t] != ref_e[t-l]) begin
        if (r.err == 0) begin
          r.fe = ref_e[t-l];
          r.fa = act[d][t];
          r.fi = r.cmp;
        end
        if (r.err != 16'hFFFF) r.err++;
      end
      if (r.cmp != 16'hFFFF) r.cmp++;
      if (d == 3 && r.err != 0) break;
    end
    r.pass = r.err == 0 && r.cmp != 0;
    return r;
  endfunction
  task automatic chk(input string name, input int d, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, got, want);
    end
  endtask
  task automatic prep(input bit [3:0] fm, input logic [15:0] fv, input int s);
    ref_e[e] = mux_ref(in_sel1, in_sel2, in_data1, in_data2);
    for (int d = 0; d < 4; d++) begin
      act[d][e] = fm[d] ? fv : (e >= lat_of(d) ? ref_e[e-lat_of(d)] : 16'd0);
      mux_out[d] = act[d][e];
      if (s >= 0) begin
        rec_t a, b;
        a = model(d, s, e);
        b = model(d, s, e - 1);
        if (a.err != b.err) pq[d].push_back(a.err);
      end
    end
  endtask
  task automatic adv();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    start = 1'b0;
    finish = 1'b0;
    for (int i = 0; i < n; i++) begin
      prep(4'h0, 16'd0, -1);
      adv();
    end
  endtask
  task automatic zero_chk();
    for (int d = 0; d < 4; d++) begin
      chk("rst_busy", d, 32'(busy[d]), 0);
      chk("rst_done", d, 32'(done[d]), 0);
      chk("rst_pass", d, 32'(pass[d]), 0);
      chk("rst_err_pulse", d, 32'(err_pulse[d]), 0);
      chk("rst_cmp_cnt", d, 32'(cmp_cnt[d]), 0);
      chk("rst_err_cnt", d, 32'(err_cnt[d]), 0);
      chk("rst_first_exp", d, 32'(first_exp[d]), 0);
      chk("rst_first_act", d, 32'(first_act[d]), 0);
      chk("rst_first_idx", d, 32'(first_idx[d]), 0);
    end
  endtask
  // modes: 0 clean pattern, 1 one forced zero, 2 both selects low with 5678 on the output,
  // 3 three injected errors, 4 random, 5 clean pattern aborted by reset
  task automatic run(input int len, input int mode);
    int s = e;
    for (int k = 0; k <= len; k++) begin
      bit [3:0]    fm = 4'h0;
      logic [15:0] fv = 16'd0;
      int          grp = (k / 10) % 4;
      start  = k == 0 || k == 3 || k == 50;
      finish = k == len;
      in_sel1  = grp == 0 || grp == 2;
      in_sel2  = grp != 0;
      in_data1 = grp < 2 ? 16'd4096 : grp == 2 ? 16'd2048 : 16'd1024;
      in_data2 = grp == 3 ? 16'd5678 : 16'd1234;
      if (mode == 1 && k == 5) fm = 4'hF;
      if (mode == 2) begin
        in_sel1 = 1'b0; in_sel2 = 1'b0; in_data1 = 16'd2048; in_data2 = 16'd5678;
        fm = 4'hF; fv = 16'd5678;
      end
      if (mode == 3 && (k == 20 || k == 40 || k == 60)) begin
        fm = 4'hF; fv = 16'hDEAD;
      end
      if (mode == 4) begin
        in_sel1 = 1'($urandom); in_sel2 = 1'($urandom);
        in_data1 = 16'($urandom); in_data2 = 16'($urandom);
        for (int d = 0; d < 4; d++) fm[d] = $urandom_range(0, 15) == 0;
        fv = 16'($urandom);
      end
      if (mode == 5 && k == 30) begin
        reset = 1'b1; start = 1'b0; finish = 1'b0;
        prep(4'h0, 16'd0, -1);
        adv();
        reset = 1'b0;
        zero_chk();
        return;
      end
      prep(fm, fv, s);
      if (finish) for (int d = 0; d < 4; d++) rq[d].push_back(model(d, s, e));
      adv();
      if (k < 10) chk("lat7_cmp_early", 2, 32'(cmp_cnt[2]), 32'(model(2, s, e - 1).cmp));
      if (mode == 3 && k == 50) begin
        for (int d = 0; d < 4; d++) begin
          chk("mid_cmp_cnt", d, 32'(cmp_cnt[d]), 32'(model(d, s, e - 1).cmp));
          chk("mid_err_cnt", d, 32'(err_cnt[d]), 32'(model(d, s, e - 1).err));
          chk("mid_busy", d, 32'(busy[d]), 1);
          chk("mid_done", d, 32'(done[d]), 0);
        end
      end
    end
  endtask
  initial for (int d = 0; d < 4; d++) done_p[d] = 1'b0;
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (err_pulse[d] === 1'b1) begin
        if (pq[d].size() == 0) chk("unexpected_err_pulse", d, 1, 0);
        else chk("err_pulse_count", d, 32'(err_cnt[d]), 32'(pq[d].pop_front()));
      end
      if (done[d] === 1'b1 && done_p[d] !== 1'b1) begin
        if (rq[d].size() == 0) chk("unexpected_done", d, 1, 0);
        else begin
          mr = rq[d].pop_front();
          chk("cmp_cnt", d, 32'(cmp_cnt[d]), 32'(mr.cmp));
          chk("err_cnt", d, 32'(err_cnt[d]), 32'(mr.err));
          chk("pass", d, 32'(pass[d]), 32'(mr.pass));
          chk("first_exp", d, 32'(first_exp[d]), 32'(mr.fe));
          chk("first_act", d, 32'(first_act[d]), 32'(mr.fa));
          chk("first_idx", d, 32'(first_idx[d]), 32'(mr.fi));
          chk("busy_in_done", d, 32'(busy[d]), 0);
        end
      end
      done_p[d] = done[d];
    end
  end
  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0;
    in_sel1 = 1'b0; in_sel2 = 1'b0; in_data1 = 16'd0; in_data2 = 16'd0;
    for (int d = 0; d < 4; d++) mux_out[d] = 16'd0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prep(4'h0, 16'd0, -1);
      adv();
    end
    reset = 1'b0;
    zero_chk();
    run(120, 0);
    idle(2);
    run(120, 1);
    idle(2);
    run(20, 2);
    idle(2);
    run(120, 3);
    idle(2);
    run(120, 5);
    idle(2);
    run(120, 0);
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      run($urandom_range(20, 80), 4);
    end
    idle(4);
    for (int d = 0; d < 4; d++) begin
      chk("result_never_reported", d, 32'(rq[d].size()), 0);
      chk("err_pulse_missing", d, 32'(pq[d].size()), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
